bcd_countdown_timer: RTL

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

---
 rtl/bcd_countdown_timer_pkg.sv | 32 +++
 rtl/bcd_countdown_timer_if.sv | 26 ++
 rtl/bcd_digit_down.sv | 30 +++
 rtl/bcd_countdown_timer.sv | 90 +++++++++
 4 files changed

// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// A time value is six BCD digits, least significant (seconds ones) first.
package bcd_countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED,
        ST_EXPIRED
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t        SEC_TENS_MAX = 4'd5;
    localparam bcd_t        DIGIT_MAX    = 4'd9;
    localparam logic [23:0] TIME_ZERO    = 24'h000000;
    localparam logic [23:0] TIME_ONE_SEC = 24'h000001;
    localparam int          NUM_DIGITS   = 6;

    // Digit index 1 and 3 are the seconds/minutes tens positions.
    function automatic bcd_t digit_max(input int idx);
        return (idx == 1 || idx == 3) ? SEC_TENS_MAX : DIGIT_MAX;
    endfunction

    function automatic logic load_valid(input logic [7:0] hh, input logic [7:0] mm,
                                        input logic [7:0] ss);
        return (hh[7:4] <= DIGIT_MAX)    && (hh[3:0] <= DIGIT_MAX) &&
               (mm[7:4] <= SEC_TENS_MAX) && (mm[3:0] <= DIGIT_MAX) &&
               (ss[7:4] <= SEC_TENS_MAX) && (ss[3:0] <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control strobes, load value and remaining-time outputs of the countdown timer.
interface bcd_countdown_timer_if;
    logic       tick;
    logic       load;
    logic       start;
    logic       pause;
    logic [7:0] ld_hh;
    logic [7:0] ld_mm;
    logic [7:0] ld_ss;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       running;
    logic       done;
    logic       load_err;

    modport master (
        output tick, load, start, pause, ld_hh, ld_mm, ld_ss,
        input  hh, mm, ss, running, done, load_err
    );

    modport slave (
        input  tick, load, start, pause, ld_hh, ld_mm, ld_ss,
        output hh, mm, ss, running, done, load_err
    );
endinterface

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit: wraps 0 -> MAX and borrows from the next digit.
module bcd_digit_down
    import bcd_countdown_timer_pkg::*;
#(
    parameter bcd_t MAX = DIGIT_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  bcd_t i_load_val,
    input  logic i_borrow_in,
    output logic o_borrow_out,
    output bcd_t o_digit
);

    bcd_t r_digit;

    always_ff @(posedge clk) begin
        if (reset)
            r_digit <= '0;
        else if (i_load)
            r_digit <= i_load_val;
        else if (i_borrow_in)
            r_digit <= (r_digit == '0) ? MAX : r_digit - 4'd1;
    end

    assign o_borrow_out = i_borrow_in && (r_digit == '0);
    assign o_digit      = r_digit;

endmodule

// File: rtl/bcd_countdown_timer.sv
// HH:MM:SS BCD countdown timer with load/start/pause strobes and an expiry pulse.
// Strobe priority per cycle: load > pause > start > tick.
module bcd_countdown_timer (
    input  logic                  clk,
    input  logic                  reset,
    bcd_countdown_timer_if.slave  bus
);
    import bcd_countdown_timer_pkg::*;

    state_e                     r_state;
    state_e                     w_next_state;
    bcd_t [NUM_DIGITS-1:0]      w_digits;
    bcd_t [NUM_DIGITS-1:0]      w_ld_val;
    logic [NUM_DIGITS:0]        w_bin;
    logic                       w_ld;
    logic                       w_dec;
    logic                       w_load_ok;
    logic                       w_zero;
    logic                       w_last;
    logic                       w_underflow;
    logic                       w_done_nxt;
    logic                       w_err_nxt;
    logic                       r_done;
    logic                       r_err;

    assign w_ld_val    = {bus.ld_hh, bus.ld_mm, bus.ld_ss};
    assign w_load_ok   = load_valid(bus.ld_hh, bus.ld_mm, bus.ld_ss);
    assign w_zero      = (w_digits == TIME_ZERO);
    assign w_last      = (w_digits == TIME_ONE_SEC);
    assign w_dec       = bus.tick && !bus.load && !bus.pause && !bus.start && (r_state == ST_RUN);
    assign w_bin[0]    = w_dec;
    // RUN never holds zero, so a borrow out of the top digit is unreachable; land in EXPIRED if it ever happens.
    assign w_underflow = w_bin[NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit_down #(.MAX(digit_max(g))) u_digit (
            .clk          (clk),
            .reset        (reset),
            .i_load       (w_ld),
            .i_load_val   (w_ld_val[g]),
            .i_borrow_in  (w_bin[g]),
            .o_borrow_out (w_bin[g+1]),
            .o_digit      (w_digits[g])
        );
    end

    always_comb begin
        w_next_state = r_state;
        w_ld         = 1'b0;
        w_err_nxt    = 1'b0;
        w_done_nxt   = 1'b0;
        if (bus.load) begin
            if (w_load_ok) begin
                w_ld         = 1'b1;
                w_next_state = ST_IDLE;
            end else begin
                w_err_nxt = 1'b1;
            end
        end else if (bus.pause) begin
            if (r_state == ST_RUN)
                w_next_state = ST_PAUSED;
        end else if (bus.start) begin
            if ((r_state == ST_IDLE || r_state == ST_PAUSED) && !w_zero)
                w_next_state = ST_RUN;
        end else if (w_dec && (w_last || w_underflow)) begin
            w_next_state = ST_EXPIRED;
            w_done_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bus.hh       = {w_digits[5], w_digits[4]};
    assign bus.mm       = {w_digits[3], w_digits[2]};
    assign bus.ss       = {w_digits[1], w_digits[0]};
    assign bus.running  = (r_state == ST_RUN);
    assign bus.done     = r_done;
    assign bus.load_err = r_err;

endmodule
